// File: rtl/seq_divider_if.sv
// Divider request/response bundle between the execute stage (master) and seq_divider (slave).
interface seq_divider_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            start;
    logic            signed_div;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            status;
    logic            finished;

    modport master (
        output dividend, divisor, start, signed_div,
        input  quotient, remainder, status, finished
    );

    modport slave (
        input  dividend, divisor, start, signed_div,
        output quotient, remainder, status, finished
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, XLEN iterations, signed/unsigned, combinational divide-by-zero result.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module seq_divider #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvd_r;
    logic [XLEN-1:0] dsr_r;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] q_out, r_out;

    logic            dvd_neg, dsr_neg, div_zero, load;
    logic [XLEN-1:0] dvd_mag, dsr_mag;
    logic [XLEN:0]   shift_rem, diff;
    logic            q_bit, last;
    logic [XLEN-1:0] rem_nxt, quo_nxt;

    assign dvd_neg  = bus.signed_div & bus.dividend[XLEN-1];
    assign dsr_neg  = bus.signed_div & bus.divisor[XLEN-1];
    // Negating 2^(XLEN-1) wraps to itself, which is the correct unsigned magnitude.
    assign dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
    assign dsr_mag  = dsr_neg ? -bus.divisor  : bus.divisor;
    assign div_zero = (bus.divisor == '0);
    assign load     = (state == IDLE) && bus.start && !div_zero;

`ifdef DIV_EARLY_OUT_EN
    logic early;
    assign early = dvd_mag < dsr_mag;
`endif

    // Partial remainder stays below the divisor, so an XLEN+1-bit trial subtract cannot overflow.
    assign shift_rem = {rem_r, dvd_r[XLEN-1]};
    assign diff      = shift_rem - {1'b0, dsr_r};
    assign q_bit     = ~diff[XLEN];
    assign rem_nxt   = q_bit ? diff[XLEN-1:0] : shift_rem[XLEN-1:0];
    assign quo_nxt   = {dvd_r[XLEN-2:0], q_bit};
    assign last      = (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
`ifdef DIV_EARLY_OUT_EN
                    state_nxt = early ? DONE : BUSY;
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (!bus.start) state_nxt = IDLE;
                else if (last)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r <= '0;
            dvd_r <= '0;
            dsr_r <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            q_out <= '0;
            r_out <= '0;
        end else begin
            if (load) begin
                rem_r <= '0;
                dvd_r <= dvd_mag;
                dsr_r <= dsr_mag;
                cnt   <= '0;
                neg_q <= dvd_neg ^ dsr_neg;
                neg_r <= dvd_neg;
`ifdef DIV_EARLY_OUT_EN
                if (early) begin
                    q_out <= '0;
                    r_out <= bus.dividend;
                end
`endif
            end else if (state == BUSY && bus.start) begin
                rem_r <= rem_nxt;
                dvd_r <= quo_nxt;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    q_out <= neg_q ? -quo_nxt : quo_nxt;
                    r_out <= neg_r ? -rem_nxt : rem_nxt;
                end
            end
        end
    end

    // Zero divisor answers in the request cycle so execute never stalls on it.
    always_comb begin
        bus.quotient  = q_out;
        bus.remainder = r_out;
        if (state == IDLE && bus.start && div_zero) begin
            bus.quotient  = '1;
            bus.remainder = bus.dividend;
        end
    end

    assign bus.status   = (state == BUSY);
    assign bus.finished = (state == DONE);
endmodule

// File: tb/tb_seq_divider.sv
// Directed + random bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_divider_if #(.XLEN(XLEN)) bus ();
    seq_divider #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    logic [XLEN-1:0] last_q, last_r;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics via 64-bit arithmetic; truncating division gives remainder the dividend's sign.
    function automatic void ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s,
                                    output logic [XLEN-1:0] q, output logic [XLEN-1:0] r, output int lat);
        longint sa, sb, ma, mb;
        sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = s ? longint'($signed(b)) : longint'({32'b0, b});
        q   = XLEN'(sa / sb);
        r   = XLEN'(sa % sb);
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        lat = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) lat = 1;
`else
        if (ma < 0 || mb < 0) lat = 0;
`endif
    endfunction

    // Called at posedge+1; issues one op and follows it cycle by cycle through DONE.
    task automatic run_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s, input bit drop);
        logic [XLEN-1:0] eq, er;
        int lat;
        ref_div(a, b, s, eq, er, lat);
        bus.dividend   = a;
        bus.divisor    = b;
        bus.signed_div = s;
        bus.start      = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk("status", XLEN'(bus.status), XLEN'(c >= 1 && c < lat));
            chk("finished", XLEN'(bus.finished), XLEN'(c == lat));
            if (c == lat) begin
                chk("quotient", bus.quotient, eq);
                chk("remainder", bus.remainder, er);
            end
            @(posedge clk); #1;
        end
        last_q = eq;
        last_r = er;
        if (drop) begin
            bus.start = 1'b0;
            @(negedge clk);
            chk("idle_status", XLEN'(bus.status), '0);
            chk("idle_finished", XLEN'(bus.finished), '0);
            chk("held_quotient", bus.quotient, last_q);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [XLEN-1:0] a, b;
        logic s;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.signed_div = 1'b0;
        #3;
        chk("rst_quotient", bus.quotient, '0);
        chk("rst_remainder", bus.remainder, '0);
        chk("rst_status", XLEN'(bus.status), '0);
        chk("rst_finished", XLEN'(bus.finished), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_div(32'd100, 32'd7, 1'b0, 1'b1);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);

        // Divide by zero: same-cycle result, no state change.
        bus.dividend   = 32'h1234;
        bus.divisor    = '0;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        #1;
        chk("dz_quotient", bus.quotient, 32'hFFFF_FFFF);
        chk("dz_remainder", bus.remainder, 32'h1234);
        chk("dz_status", XLEN'(bus.status), '0);
        chk("dz_finished", XLEN'(bus.finished), '0);
        @(posedge clk); #1;
        bus.signed_div = 1'b1;
        bus.dividend   = 32'h8000_0005;
        #1;
        chk("dz_s_status", XLEN'(bus.status), '0);
        chk("dz_s_quotient", bus.quotient, 32'hFFFF_FFFF);
        chk("dz_s_remainder", bus.remainder, 32'h8000_0005);
        bus.start = 1'b0;
        #1;
        chk("dz_release_q", bus.quotient, last_q);
        @(posedge clk); #1;

        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_div(32'd50, 32'd5, 1'b0, 1'b0);
        run_div(32'd9, 32'd4, 1'b0, 1'b1);

        // Flush: drop start in BUSY cycle 5.
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("flush_busy", XLEN'(bus.status), 32'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("flush_status", XLEN'(bus.status), '0);
        chk("flush_finished", XLEN'(bus.finished), '0);
        chk("flush_quotient", bus.quotient, last_q);
        chk("flush_remainder", bus.remainder, last_r);
        @(posedge clk); #1;
        chk("flush_no_pulse", XLEN'(bus.finished), '0);

        // Asynchronous reset mid-iteration.
        bus.dividend = 32'd77777;
        bus.divisor  = 32'd13;
        bus.start    = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("rstb_busy", XLEN'(bus.status), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstb_status", XLEN'(bus.status), '0);
        chk("rstb_finished", XLEN'(bus.finished), '0);
        chk("rstb_quotient", bus.quotient, '0);
        chk("rstb_remainder", bus.remainder, '0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        last_q = '0;
        last_r = '0;
        @(posedge clk); #1;
        chk("rstb_after", XLEN'(bus.finished), '0);

        run_div(32'd3, 32'd8, 1'b0, 1'b1);

        for (int i = 0; i < 14; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = XLEN'($urandom_range(1, 20));
                2:       begin a = XLEN'($urandom_range(0, 50)); b = XLEN'($urandom_range(51, 500)); end
                default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            endcase
            if (b == '0) b = 32'd1;
            run_div(a, b, s, ($urandom_range(0, 2) != 0));
        end
        bus.start = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
